// File: rtl/irq_controller.sv
// irq_controller: machine timer (mtime/mtimecmp) plus NUM_EXT edge-triggered
// external lines, fixed-priority arbitration and a request/ack/complete FSM
// driving a single interrupt request. Memory-mapped register window.
// Optional build macro: IRQ_CTRL_SYNC_EN adds a two-flop synchronizer per
// ext_irq line ahead of edge detection.
module irq_controller #(
  parameter int unsigned NUM_EXT  = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic [4:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_we,
  input  logic               bus_re,
  output logic [31:0]        bus_rdata,
  input  logic               int_ack,
  input  logic               int_complete,
  output logic               interrupt,
  output logic [3:0]         int_id
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned NS = NUM_EXT + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tpend_q, tpend_d;
  logic [NUM_EXT-1:0] epend_q, epend_d;
  logic [NUM_EXT:0]   enable_q, enable_d;
  logic [3:0]         claim_q, claim_d;
  logic [1:0]         state_q, state_d;
  logic               interrupt_q, interrupt_d;
  logic [3:0]         int_id_q, int_id_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_EXT-1:0] hist_q, hist_d;
  logic [NUM_EXT-1:0] ext_src;

  logic [2:0]         waddr;
  logic [NS-1:0]      masked;
  logic               req;
  logic [3:0]         best;
  logic [NUM_EXT-1:0] w1c_mask;
  logic [NUM_EXT-1:0] claim_clr;
  logic [NUM_EXT-1:0] ext_edge;
  logic               unused_addr;

  assign waddr       = bus_addr[4:2];
  assign unused_addr = ^bus_addr[1:0];

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_EXT-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous external lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
    end
  end

  assign ext_src = sync2_q;
`else
  assign ext_src = ext_irq;
`endif

  // Pending/enable masking and lowest-id-wins arbitration
  always_comb begin
    masked = {epend_q, tpend_q} & enable_q;
    req    = |masked;
    best   = 4'd0;
    for (int i = int'(NS) - 1; i >= 0; i--) begin
      if (masked[i]) best = 4'(i);
    end
  end

  // Next-state logic: timer, pending, registers, FSM, outputs and read data
  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    presc_d     = presc_q;
    enable_d    = enable_q;
    claim_d     = claim_q;
    state_d     = state_q;
    rdata_d     = rdata_q;
    w1c_mask    = '0;
    claim_clr   = '0;
    ext_edge    = ext_src & ~hist_q;
    hist_d      = ext_src;
    tpend_d     = (mtime_q >= mtimecmp_q);

    // A software write to mtime overrides this cycle's increment
    if (bus_we && (waddr == 3'd0)) begin
      mtime_d[31:0] = bus_wdata;
      presc_d       = '0;
    end else if (bus_we && (waddr == 3'd1)) begin
      mtime_d[63:32] = bus_wdata;
      presc_d        = '0;
    end else if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (bus_we) begin
      case (waddr)
        3'd2:    mtimecmp_d[31:0]  = bus_wdata;
        3'd3:    mtimecmp_d[63:32] = bus_wdata;
        3'd4:    w1c_mask          = bus_wdata[NUM_EXT:1];
        3'd5:    enable_d          = bus_wdata[NUM_EXT:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_REQ;
      end
      S_REQ: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (int_ack) begin
          claim_d = best;
          state_d = S_SERVICE;
          if (best != 4'd0) claim_clr = NUM_EXT'(1) << (best - 4'd1);
        end
      end
      S_SERVICE: begin
        if (int_complete) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new edge beats a simultaneous clear
    epend_d = (epend_q & ~w1c_mask & ~claim_clr) | ext_edge;

    interrupt_d = (state_d == S_REQ);
    if (state_d == S_REQ)          int_id_d = best;
    else if (state_d == S_SERVICE) int_id_d = claim_d;
    else                           int_id_d = 4'd0;

    // Reads sample pre-write values
    if (bus_re) begin
      case (waddr)
        3'd0:    rdata_d = mtime_q[31:0];
        3'd1:    rdata_d = mtime_q[63:32];
        3'd2:    rdata_d = mtimecmp_q[31:0];
        3'd3:    rdata_d = mtimecmp_q[63:32];
        3'd4:    rdata_d = 32'({epend_q, tpend_q});
        3'd5:    rdata_d = 32'(enable_q);
        3'd6:    rdata_d = 32'(claim_q);
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      presc_q     <= '0;
      tpend_q     <= 1'b0;
      epend_q     <= '0;
      enable_q    <= '0;
      claim_q     <= 4'd0;
      state_q     <= S_IDLE;
      interrupt_q <= 1'b0;
      int_id_q    <= 4'd0;
      rdata_q     <= 32'd0;
      hist_q      <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      presc_q     <= presc_d;
      tpend_q     <= tpend_d;
      epend_q     <= epend_d;
      enable_q    <= enable_d;
      claim_q     <= claim_d;
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      int_id_q    <= int_id_d;
      rdata_q     <= rdata_d;
      hist_q      <= hist_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign interrupt = interrupt_q;
  assign int_id    = int_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (NUM_EXT=4, PRESCALE=1, no synchronizer).
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ext_irq = 4'd0;
  logic [4:0]  bus_addr = 5'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        int_ack = 1'b0;
  logic        int_complete = 1'b0;
  logic        interrupt;
  logic [3:0]  int_id;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_EXT(4), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .int_ack(int_ack), .int_complete(int_complete),
    .interrupt(interrupt), .int_id(int_id)
  );

  always #5 clk = ~clk;

  // Stimulus drivers; all are entered and left on a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  task automatic pulse_complete();
    int_complete = 1'b1;
    @(negedge clk);
    int_complete = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b1;
    tick(2);
    checks++;
    if (interrupt !== 1'b0 || int_id !== 4'd0 || bus_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got irq=%b id=%0d rdata=%h, expected 0/0/0", interrupt, int_id, bus_rdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_read(5'(i * 4), d);
      checks++;
      if (d !== exp_tab[i]) begin
        errors++;
        $display("FAIL reset_read_%0h: got %h expected %h", i * 4, d, exp_tab[i]);
      end
    end
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq_idle: got %b expected 0", interrupt);
    end
  endtask

  task automatic test_timer();
    bus_write(5'h14, 32'h1);
    bus_write(5'h08, 32'h10);
    bus_write(5'h04, 32'h0);
    bus_write(5'h00, 32'h0);       // mtime=0 after this edge (E0)
    bus_write(5'h0C, 32'h0);       // now past E0+1
    tick(16);                      // past E0+17: mtime hit 0x10 at E0+16, pending at E0+17
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL timer_early: got irq=%b expected 0", interrupt);
    end
    tick(1);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 4'd0) begin
      errors++;
      $display("FAIL timer_rise: got irq=%b id=%0d expected 1/0", interrupt, int_id);
    end
    pulse_ack();
    checks++;
    if (interrupt !== 1'b0 || int_id !== 4'd0) begin
      errors++;
      $display("FAIL timer_ack: got irq=%b id=%0d expected 0/0", interrupt, int_id);
    end
    pulse_complete();
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL timer_complete: got irq=%b expected 0", interrupt);
    end
    tick(1);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 4'd0) begin
      errors++;
      $display("FAIL timer_rerequest: got irq=%b id=%0d expected 1/0", interrupt, int_id);
    end
    bus_write(5'h0C, 32'hFFFF_FFFF);
    bus_write(5'h14, 32'h0);
    tick(3);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL timer_cleanup: got irq=%b expected 0", interrupt);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_write(5'h14, 32'hC);       // enable ids 2 and 3
    ext_irq = 4'b0110;             // ids 2 and 3 together
    tick(2);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 4'd2) begin
      errors++;
      $display("FAIL prio_first: got irq=%b id=%0d expected 1/2", interrupt, int_id);
    end
    pulse_ack();
    checks++;
    if (interrupt !== 1'b0 || int_id !== 4'd2) begin
      errors++;
      $display("FAIL prio_service: got irq=%b id=%0d expected 0/2", interrupt, int_id);
    end
    bus_read(5'h18, d);
    checks++;
    if (d !== 32'd2) begin
      errors++;
      $display("FAIL prio_claim: got %h expected 2", d);
    end
    bus_read(5'h10, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL prio_pending: got %h expected 8", d);
    end
    pulse_complete();
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL prio_complete: got irq=%b expected 0", interrupt);
    end
    tick(1);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 4'd3) begin
      errors++;
      $display("FAIL prio_second: got irq=%b id=%0d expected 1/3", interrupt, int_id);
    end
    pulse_ack();
    pulse_complete();
    ext_irq = 4'b0000;
    tick(2);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL prio_drained: got irq=%b expected 0", interrupt);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    bus_write(5'h14, 32'h2);
    ext_irq = 4'b0001;
    tick(2);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 4'd1) begin
      errors++;
      $display("FAIL w1c_req: got irq=%b id=%0d expected 1/1", interrupt, int_id);
    end
    bus_write(5'h10, 32'h2);
    tick(1);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL w1c_idle: got irq=%b expected 0", interrupt);
    end
    bus_read(5'h10, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL w1c_pending: got %h expected 0", d);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] d;
    pulse_ack();                   // IDLE: ignored
    checks++;
    if (interrupt !== 1'b0 || int_id !== 4'd0) begin
      errors++;
      $display("FAIL ign_ack_idle: got irq=%b id=%0d expected 0/0", interrupt, int_id);
    end
    bus_read(5'h18, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL ign_claim: got %h expected 3", d);
    end
    bus_read(5'h10, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ign_pending_idle: got %h expected 0", d);
    end
    ext_irq = 4'b0000;
    tick(1);
    ext_irq = 4'b0001;
    tick(2);
    pulse_complete();              // REQ: ignored
    checks++;
    if (interrupt !== 1'b1 || int_id !== 4'd1) begin
      errors++;
      $display("FAIL ign_complete_req: got irq=%b id=%0d expected 1/1", interrupt, int_id);
    end
    bus_read(5'h10, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL ign_pending_req: got %h expected 2", d);
    end
    pulse_ack();
    pulse_complete();
  endtask

  task automatic test_read_during_write();
    logic [31:0] d;
    bus_addr = 5'h14; bus_wdata = 32'h5; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    checks++;
    if (bus_rdata !== 32'h2) begin
      errors++;
      $display("FAIL rw_old_value: got %h expected 2", bus_rdata);
    end
    bus_read(5'h14, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL rw_new_value: got %h expected 5", d);
    end
    bus_write(5'h14, 32'h0);
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] d;
    bus_write(5'h04, 32'hFFFF_FFFF);
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_read(5'h00, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_lo_max: got %h expected ffffffff", d);
    end
    bus_read(5'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL wrap_hi_zero: got %h expected 0", d);
    end
    bus_read(5'h00, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL wrap_lo_one: got %h expected 1", d);
    end

    bus_write(5'h14, 32'h2);
    ext_irq = 4'b0000;
    tick(1);
    ext_irq = 4'b0001;
    tick(2);
    pulse_ack();
    bus_read(5'h14, d);
    checks++;
    if (int_id !== 4'd1 || interrupt !== 1'b0 || d !== 32'h2) begin
      errors++;
      $display("FAIL svc_before_rst: got irq=%b id=%0d rdata=%h expected 0/1/2", interrupt, int_id, d);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (interrupt !== 1'b0 || int_id !== 4'd0 || bus_rdata !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got irq=%b id=%0d rdata=%h expected 0/0/0", interrupt, int_id, bus_rdata);
    end
    @(negedge clk);
    rst = 1'b0;                    // ext_irq[0] still high: one edge after release
    bus_read(5'h18, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL post_rst_claim: got %h expected 0", d);
    end
    bus_read(5'h10, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL post_rst_pending: got %h expected 2", d);
    end
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_irq: got %b expected 0", interrupt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_timer();
    test_priority();
    test_w1c();
    test_ignored();
    test_read_during_write();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
